// File: rtl/vjtag_mem_bridge.sv
// vjtag_mem_bridge: decodes the 2-bit virtual JTAG IR into BYPASS/ADDR/WRITE/READ
// and drives a synchronous pixel memory port, all in the tck domain.
module vjtag_mem_bridge #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              tck,
  input  logic              rst_n,
  input  logic              tdi,
  output logic              tdo,
  input  logic [1:0]        ir_in,
  output logic [1:0]        ir_out,
  input  logic              virtual_state_cdr,
  input  logic              virtual_state_sdr,
  input  logic              virtual_state_udr,
  input  logic              virtual_state_uir,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {BYP = 2'b00, ADR = 2'b01, WR = 2'b10, RD = 2'b11} ir_t;
  ir_t               r_ir;
  logic [ADDR_W-1:0] r_addr, r_addr_sr;
  logic [DATA_W-1:0] r_data_sr, r_rd_buf, r_wdata;
  logic              r_byp, r_we, r_re, r_re_d, r_ovf, r_rd_valid;
  assign tdo       = (r_ir == BYP) ? r_byp : (r_ir == ADR) ? r_addr_sr[0] : r_data_sr[0];
  assign ir_out    = {r_ovf, r_rd_valid};
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;
  assign mem_re    = r_re;
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_ir       <= BYP;
      r_addr     <= '0;
      r_addr_sr  <= '0;
      r_data_sr  <= '0;
      r_byp      <= 1'b0;
      r_rd_buf   <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_re_d     <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_re   <= 1'b0;
      r_re_d <= r_re;
      if (virtual_state_uir) r_ir <= ir_t'(ir_in);
      if (r_re_d) begin
        r_rd_buf   <= mem_rdata;
        r_rd_valid <= 1'b1;
      end
      // post-write increment; a udr below overrides it
      if (r_we) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (&r_addr) r_ovf <= 1'b1;
      end
      if (virtual_state_udr) begin
        case (r_ir)
          ADR: begin
            r_addr     <= r_addr_sr;
            r_ovf      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_re       <= 1'b1;
          end
          WR: begin
            r_wdata <= r_data_sr;
            r_we    <= 1'b1;
          end
          RD: begin
            r_addr     <= r_addr + ADDR_W'(1);
            r_re       <= 1'b1;
            r_rd_valid <= 1'b0;
          end
          default: ;
        endcase
      end else if (virtual_state_sdr) begin
        case (r_ir)
          BYP:     r_byp     <= tdi;
          ADR:     r_addr_sr <= {tdi, r_addr_sr[ADDR_W-1:1]};
          default: r_data_sr <= {tdi, r_data_sr[DATA_W-1:1]};
        endcase
      end else if (virtual_state_cdr) begin
        case (r_ir)
          ADR:     r_addr_sr <= r_addr;
          WR:      r_data_sr <= '0;
          RD:      r_data_sr <= r_rd_buf;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vjtag_mem_bridge.sv
// tb_vjtag_mem_bridge: scoreboard bench; expected memory writes and read strobes
// are queued as scans are issued and popped when the DUT pulses mem_we/mem_re.
module tb_vjtag_mem_bridge;
  logic        tck = 1'b0, rst_n = 1'b0, tdi = 1'b0;
  logic        cdr = 1'b0, sdr = 1'b0, udr = 1'b0, uir = 1'b0;
  logic [1:0]  ir_in = 2'b00;
  logic        tdo, mem_we, mem_re;
  logic [1:0]  ir_out;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  mem [65536];
  logic [23:0] wq[$];
  logic [15:0] rq[$];
  int          errs = 0, checks = 0;
  logic [31:0] got;

  vjtag_mem_bridge dut (
    .tck(tck), .rst_n(rst_n), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
    .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_udr(udr),
    .virtual_state_uir(uir), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 tck = ~tck;

  always @(posedge tck) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge tck) if (rst_n) begin
    if (mem_we) begin
      if (wq.size() == 0) chk("we_unexpected", {mem_addr, mem_wdata}, 0);
      else chk("we_addr_data", {mem_addr, mem_wdata}, wq.pop_front());
    end
    if (mem_re) begin
      if (rq.size() == 0) chk("re_unexpected", mem_addr, 32'hdead);
      else chk("re_addr", mem_addr, rq.pop_front());
    end
  end

  task automatic set_ir(input logic [1:0] code);
    ir_in = code; uir = 1'b1;
    @(negedge tck); uir = 1'b0;
  endtask

  task automatic scan(input logic [31:0] val, input int n, output logic [31:0] out);
    out = '0;
    cdr = 1'b1;
    @(negedge tck); cdr = 1'b0;
    for (int i = 0; i < n; i++) begin
      sdr = 1'b1; tdi = val[i]; out[i] = tdo;
      @(negedge tck);
    end
    sdr = 1'b0; udr = 1'b1;
    @(negedge tck); udr = 1'b0;
    repeat (2) @(negedge tck);
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] exp_tdo;
    logic [7:0] wd [3];
    pat = 4'b1101;
    exp_tdo = 4'b1010;
    wd[0] = 8'hA5; wd[1] = 8'h3C; wd[2] = 8'hFF;
    repeat (3) @(negedge tck);
    chk("rst_tdo", tdo, 0);
    chk("rst_ir_out", ir_out, 0);
    chk("rst_we_re", {mem_we, mem_re}, 0);
    rst_n = 1'b1;
    @(negedge tck);
    for (int i = 0; i < 4; i++) begin
      sdr = 1'b1; tdi = pat[i];
      chk($sformatf("byp_tdo%0d", i), tdo, exp_tdo[i]);
      @(negedge tck);
    end
    sdr = 1'b0;
    set_ir(2'b01);
    rq.push_back(16'h1234);
    scan(32'h1234, 16, got);
    chk("addr_capture0", got, 0);
    chk("addr_load", mem_addr, 16'h1234);
    chk("addr_ir_out", ir_out, 2'b01);
    set_ir(2'b01);
    rq.push_back(16'h0010);
    scan(32'h0010, 16, got);
    chk("addr_capture1", got, 16'h1234);
    set_ir(2'b10);
    for (int i = 0; i < 3; i++) begin
      wq.push_back({16'h0010 + 16'(i), wd[i]});
      scan({24'h0, wd[i]}, 8, got);
    end
    chk("burst_final_addr", mem_addr, 16'h0013);
    set_ir(2'b01);
    rq.push_back(16'h0010);
    scan(32'h0010, 16, got);
    set_ir(2'b11);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_valid%0d", i), ir_out[0], 1);
      rq.push_back(16'h0011 + 16'(i));
      scan(0, 8, got);
      chk($sformatf("rd_data%0d", i), got, {24'h0, wd[i]});
    end
    chk("rd_final_addr", mem_addr, 16'h0012);
    set_ir(2'b01);
    rq.push_back(16'hFFFF);
    scan(32'hFFFF, 16, got);
    set_ir(2'b10);
    wq.push_back({16'hFFFF, 8'h55});
    scan(32'h55, 8, got);
    chk("wrap_addr", mem_addr, 0);
    chk("wrap_ovf", ir_out[1], 1);
    set_ir(2'b01);
    rq.push_back(16'h0000);
    scan(0, 16, got);
    chk("ovf_cleared", ir_out[1], 0);
    set_ir(2'b01);
    rq.push_back(16'h0020);
    scan(32'h0020, 16, got);
    set_ir(2'b10);
    cdr = 1'b1;
    @(negedge tck); cdr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sdr = 1'b1; tdi = 1'b1;
      @(negedge tck);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tdo", tdo, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_ir_out", ir_out, 0);
    chk("midrst_we", mem_we, 0);
    sdr = 1'b0;
    repeat (3) @(negedge tck);
    rst_n = 1'b1;
    repeat (4) @(negedge tck);
    chk("post_rst_data_sr_tdo", tdo, 0);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
